// File: rtl/twos_comp_bcd_decoder_if.sv
// Handshake/result bus between the result-register side and the two's-complement BCD decoder.
// Optional feature macro: LEADING_ZERO_BLANK_EN adds the blank vector to the bus.
interface twos_comp_bcd_decoder_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      data_in;
   logic                  busy;
   logic                  done;
   logic                  sign;
   logic [4*DIGITS-1:0]   bcd;
`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0]     blank;

   modport master (output start, data_in, input busy, done, sign, bcd, blank);
   modport slave  (input start, data_in, output busy, done, sign, bcd, blank);
`else
   modport master (output start, data_in, input busy, done, sign, bcd);
   modport slave  (input start, data_in, output busy, done, sign, bcd);
`endif
endinterface

// File: rtl/twos_comp_bcd_decoder.sv
// Sequential two's-complement to sign + BCD magnitude decoder (double dabble, one bit per cycle).
// Optional feature macro: LEADING_ZERO_BLANK_EN adds a registered leading-zero blank vector.
module twos_comp_bcd_decoder #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic CLK,
   input  logic RST,
   twos_comp_bcd_decoder_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [WIDTH-1:0]      mag;
   logic                  sign_w;
   logic [4*DIGITS-1:0]   bcd_w;
   logic [4*DIGITS-1:0]   adj;
   logic [4*DIGITS-1:0]   bcd_nx;
   logic                  busy_r;
   logic                  done_r;
   logic                  sign_r;
   logic [4*DIGITS-1:0]   bcd_r;

   // Add-3 correction on every digit >= 5, then shift the top magnitude bit into the BCD register.
   // Carry out of the top digit cannot occur for a legal DIGITS, so it is simply dropped.
   always_comb begin
      adj = bcd_w;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_w[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd_w[4*i +: 4] + 4'd3;
      end
      bcd_nx = {adj[4*DIGITS-2:0], mag[WIDTH-1]};
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_r;
   logic [DIGITS-1:0] blank_nx;

   // A digit is blanked when it and every higher digit are zero; the units digit always shows.
   always_comb begin
      logic hz;
      hz       = 1'b1;
      blank_nx = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         hz          = hz & (bcd_nx[4*i +: 4] == 4'd0);
         blank_nx[i] = hz;
      end
   end

   assign bus.blank = blank_r;
`endif

   // Control FSM and datapath: capture on start, WIDTH shift steps, one-cycle done pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         cnt    <= '0;
         mag    <= '0;
         sign_w <= 1'b0;
         bcd_w  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         sign_r <= 1'b0;
         bcd_r  <= '0;
`ifdef LEADING_ZERO_BLANK_EN
         blank_r <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  // Negation of the most negative value wraps to 2**(WIDTH-1), which is the correct magnitude.
                  sign_w <= bus.data_in[WIDTH-1];
                  mag    <= bus.data_in[WIDTH-1] ? (~bus.data_in + WIDTH'(1)) : bus.data_in;
                  bcd_w  <= '0;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_w <= bcd_nx;
               mag   <= {mag[WIDTH-2:0], 1'b0};
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  sign_r <= sign_w;
                  bcd_r  <= bcd_nx;
`ifdef LEADING_ZERO_BLANK_EN
                  blank_r <= blank_nx;
`endif
                  done_r <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sign = sign_r;
   assign bus.bcd  = bcd_r;
endmodule
